// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store stage: ls_info bit positions,
// FSM states, access sizes and size/alignment helpers.
package lsu_pkg;

  localparam int LS_W   = 11;
  localparam int LS_LB  = 10;
  localparam int LS_LH  = 9;
  localparam int LS_LW  = 8;
  localparam int LS_LD  = 7;
  localparam int LS_LBU = 6;
  localparam int LS_LHU = 5;
  localparam int LS_LWU = 4;
  localparam int LS_SB  = 3;
  localparam int LS_SH  = 2;
  localparam int LS_SW  = 1;
  localparam int LS_SD  = 0;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

  function automatic logic [1:0] ls_size(input logic [LS_W-1:0] info);
    if (info[LS_LB] | info[LS_LBU] | info[LS_SB])      return SZ_B;
    else if (info[LS_LH] | info[LS_LHU] | info[LS_SH]) return SZ_H;
    else if (info[LS_LW] | info[LS_LWU] | info[LS_SW]) return SZ_W;
    else                                               return SZ_D;
  endfunction

  function automatic logic misaligned(input logic [LS_W-1:0] info, input logic [2:0] off);
    case (ls_size(info))
      SZ_B:    return 1'b0;
      SZ_H:    return off[0];
      SZ_W:    return |off[1:0];
      default: return |off;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane steering: store byte mask and shifted data, plus
// load-data shift, truncate and sign/zero extension.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [LS_W-1:0] ls_info,
  input  logic [2:0]      off,
  input  logic [63:0]     wdata,
  input  logic [63:0]     rdata,
  output logic [7:0]      wmask,
  output logic [63:0]     wdata_sh,
  output logic [63:0]     rdata_ext
);

  logic [5:0]  sh;
  logic [63:0] wtrunc;
  logic [63:0] rsh;

  assign sh = {off, 3'b000};

  always_comb begin
    wmask  = '0;
    wtrunc = '0;
    // 8-bit shifts drop bits past lane 7, so a mask never wraps
    if (ls_info[LS_SB]) begin
      wmask  = 8'h01 << off;
      wtrunc = {56'b0, wdata[7:0]};
    end else if (ls_info[LS_SH]) begin
      wmask  = 8'h03 << off;
      wtrunc = {48'b0, wdata[15:0]};
    end else if (ls_info[LS_SW]) begin
      wmask  = 8'h0F << off;
      wtrunc = {32'b0, wdata[31:0]};
    end else if (ls_info[LS_SD]) begin
      wmask  = 8'hFF;
      wtrunc = wdata;
    end
    wdata_sh = wtrunc << sh;

    rsh       = rdata >> sh;
    rdata_ext = rsh;
    if      (ls_info[LS_LB])  rdata_ext = {{56{rsh[7]}},  rsh[7:0]};
    else if (ls_info[LS_LH])  rdata_ext = {{48{rsh[15]}}, rsh[15:0]};
    else if (ls_info[LS_LW])  rdata_ext = {{32{rsh[31]}}, rsh[31:0]};
    else if (ls_info[LS_LBU]) rdata_ext = {56'b0, rsh[7:0]};
    else if (ls_info[LS_LHU]) rdata_ext = {48'b0, rsh[15:0]};
    else if (ls_info[LS_LWU]) rdata_ext = {32'b0, rsh[31:0]};
  end

endmodule

// File: rtl/lsu.sv
// Load/store stage: single outstanding data-memory access over req/ack,
// one registered write-back beat per instruction. LSU_MISALIGN_TRAP_EN
// turns misaligned accesses into a bus-free trap beat on o_misalign.
module lsu
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [DATA_W-1:0] i_rd_data,
  input  logic [4:0]        i_rd_addr,
  input  logic              i_rd_wen,
  input  logic [ADDR_W-1:0] i_mem_addr,
  input  logic [DATA_W-1:0] i_mem_wdata,
  input  logic [LS_W-1:0]   i_ls_info,
  input  logic              i_mem_read,
  input  logic              i_mem_write,
  output logic              o_dmem_req,
  output logic              o_dmem_we,
  output logic [ADDR_W-1:0] o_dmem_addr,
  output logic [DATA_W-1:0] o_dmem_wdata,
  output logic [7:0]        o_dmem_wmask,
  input  logic              i_dmem_ack,
  input  logic [DATA_W-1:0] i_dmem_rdata,
  output logic              o_wb_valid,
  output logic              o_wb_rd_wen,
  output logic [4:0]        o_wb_rd_addr,
  output logic [DATA_W-1:0] o_wb_rd_data,
  output logic              o_misalign
);

  state_t state, state_n;

  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;
  logic [LS_W-1:0]   lat_info;
  logic              lat_we;
  logic [4:0]        lat_rd_addr;
  logic              lat_rd_wen;

  logic              wb_valid, wb_rd_wen;
  logic [4:0]        wb_rd_addr;
  logic [DATA_W-1:0] wb_rd_data;

  logic              accept, is_mem, trap;
  logic [7:0]        wmask;
  logic [63:0]       wdata_sh, rdata_ext;

  assign accept = i_valid & (state == IDLE);
  // a memory flag without any ls_info bit has nothing to access
  assign is_mem = (i_mem_read | i_mem_write) & (|i_ls_info);

`ifdef LSU_MISALIGN_TRAP_EN
  logic mis_q;
  assign trap       = is_mem & misaligned(i_ls_info, i_mem_addr[2:0]);
  assign o_misalign = mis_q;
`else
  assign trap       = 1'b0;
  assign o_misalign = 1'b0;
`endif

  lsu_align u_align (
    .ls_info   (lat_info),
    .off       (lat_addr[2:0]),
    .wdata     (lat_wdata),
    .rdata     (i_dmem_rdata),
    .wmask     (wmask),
    .wdata_sh  (wdata_sh),
    .rdata_ext (rdata_ext)
  );

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (accept && is_mem) state_n = trap ? RESP : BUS;
      BUS:     if (i_dmem_ack) state_n = RESP;
      RESP:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state       <= IDLE;
      lat_addr    <= '0;
      lat_wdata   <= '0;
      lat_info    <= '0;
      lat_we      <= 1'b0;
      lat_rd_addr <= '0;
      lat_rd_wen  <= 1'b0;
      wb_valid    <= 1'b0;
      wb_rd_wen   <= 1'b0;
      wb_rd_addr  <= '0;
      wb_rd_data  <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
      mis_q       <= 1'b0;
`endif
    end else begin
      state    <= state_n;
      wb_valid <= 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
      mis_q    <= 1'b0;
`endif
      if (accept) begin
        if (!is_mem) begin
          wb_valid   <= 1'b1;
          wb_rd_wen  <= i_rd_wen;
          wb_rd_addr <= i_rd_addr;
          wb_rd_data <= i_rd_data;
        end else
`ifdef LSU_MISALIGN_TRAP_EN
        if (trap) begin
          wb_valid   <= 1'b1;
          wb_rd_wen  <= 1'b0;
          wb_rd_addr <= i_rd_addr;
          wb_rd_data <= DATA_W'(i_mem_addr);
          mis_q      <= 1'b1;
        end else
`endif
        begin
          lat_addr    <= i_mem_addr;
          lat_wdata   <= i_mem_wdata;
          lat_info    <= i_ls_info;
          lat_we      <= i_mem_write;
          lat_rd_addr <= i_rd_addr;
          lat_rd_wen  <= i_rd_wen;
        end
      end
      if (state == BUS && i_dmem_ack) begin
        wb_valid   <= 1'b1;
        wb_rd_wen  <= lat_rd_wen & ~lat_we;
        wb_rd_addr <= lat_rd_addr;
        wb_rd_data <= rdata_ext;
      end
    end
  end

  assign o_ready      = (state == IDLE);
  assign o_dmem_req   = (state == BUS);
  assign o_dmem_we    = lat_we;
  assign o_dmem_addr  = {lat_addr[ADDR_W-1:3], 3'b000};
  assign o_dmem_wdata = wdata_sh;
  assign o_dmem_wmask = wmask;
  assign o_wb_valid   = wb_valid;
  assign o_wb_rd_wen  = wb_rd_wen;
  assign o_wb_rd_addr = wb_rd_addr;
  assign o_wb_rd_data = wb_rd_data;

endmodule
